// File: rtl/adapted_keccak_out_pipe.sv
// Registered Keccak squeeze adapter: turns squeezed words into Frodo error
// samples (or passes them raw) and tags the last word of each command.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   cmd / cmd_isReady    {numWords, skipIsLast, sample} command push
//   cmd_canReceive       command buffer not full
//   config_whichSampling one-hot table select, latched at command start
//   k__out*              squeeze input handshake, k__out_isLast on last accept
//   h__in*               registered output word handshake with last tag
//   busy                 command active or output register valid
// Optional macro ADAPTED_KECCAK_OUT_PIPE_STATS_EN adds stats_words/stats_clear,
// a saturating count of sampled words drained on h__in.
module adapted_keccak_out_pipe #(
    parameter int W         = 64,
    parameter int CMD_DEPTH = 4,
    parameter int CNT_W     = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W+1:0] cmd,
    input  logic             cmd_isReady,
    output logic             cmd_canReceive,
    input  logic [2:0]       config_whichSampling,
    input  logic [W-1:0]     k__out,
    input  logic             k__out_isReady,
    output logic             k__out_canReceive,
    output logic             k__out_isLast,
    output logic [W-1:0]     h__in,
    output logic             h__in_isReady,
    input  logic             h__in_canReceive,
    output logic             h__in_isLast,
    output logic             busy
`ifdef ADAPTED_KECCAK_OUT_PIPE_STATS_EN
    ,
    output logic [31:0]      stats_words,
    input  logic             stats_clear
`endif
);

    localparam int LANES  = W / 16;
    localparam int PTR_W  = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int FILL_W = $clog2(CMD_DEPTH + 1);

    localparam logic [14:0] TBL0 [12] = '{
        15'd4643,  15'd13363, 15'd20579, 15'd25843,
        15'd29227, 15'd31145, 15'd32103, 15'd32525,
        15'd32689, 15'd32745, 15'd32762, 15'd32766
    };
    localparam logic [14:0] TBL1 [10] = '{
        15'd5638,  15'd15915, 15'd23689, 15'd28571,
        15'd31116, 15'd32217, 15'd32613, 15'd32731,
        15'd32760, 15'd32766
    };
    localparam logic [14:0] TBL2 [6] = '{
        15'd9142,  15'd23462, 15'd30338,
        15'd32361, 15'd32725, 15'd32765
    };

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state, stateNext;

    // Command FIFO
    logic [CNT_W+1:0] fifoMem [CMD_DEPTH];
    logic [PTR_W-1:0] wrPtr, rdPtr;
    logic [FILL_W-1:0] fill;
    logic push, pop, full, empty;
    logic [CNT_W+1:0] head;
    logic [CNT_W-1:0] headNum;

    // Active command
    logic [CNT_W-1:0] cnt;
    logic skipL, sampleL;
    logic [2:0] cfgL;
    logic start, accept, lastAccept, drain;

    // Output register
    logic [W-1:0] hData;
    logic hValid, hLast;
    logic [W-1:0] sampled, wordNext;

    function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(CMD_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Lowest set config bit selects the table; no bit set forces zero.
    function automatic logic [15:0] sampleLane(
        input logic [15:0] lane,
        input logic [2:0]  cfg
    );
        logic [14:0] val;
        logic [3:0]  mag;
        logic [15:0] m;
        val = lane[15:1];
        mag = 4'd0;
        if (cfg[0]) begin
            for (int i = 0; i < 12; i++)
                if (val > TBL0[i]) mag = mag + 4'd1;
        end else if (cfg[1]) begin
            for (int i = 0; i < 10; i++)
                if (val > TBL1[i]) mag = mag + 4'd1;
        end else if (cfg[2]) begin
            for (int i = 0; i < 6; i++)
                if (val > TBL2[i]) mag = mag + 4'd1;
        end
        m = {12'd0, mag};
        // Negating a zero magnitude is still zero, so -0 needs no special case.
        return lane[0] ? (16'd0 - m) : m;
    endfunction

    assign full           = (fill == FILL_W'(CMD_DEPTH));
    assign empty          = (fill == '0);
    assign cmd_canReceive = ~full;
    assign push           = cmd_isReady & ~full;
    assign head           = fifoMem[rdPtr];
    assign headNum        = head[CNT_W+1:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            fill  <= '0;
        end else begin
            if (push) wrPtr <= ptrInc(wrPtr);
            if (pop)  rdPtr <= ptrInc(rdPtr);
            unique case ({push, pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifoMem[wrPtr] <= cmd;
    end

    assign drain             = hValid & h__in_canReceive;
    assign k__out_canReceive = (state == RUN) & (~hValid | h__in_canReceive);
    assign accept            = k__out_isReady & k__out_canReceive;
    assign lastAccept        = accept & (cnt == CNT_W'(1));
    assign k__out_isLast     = lastAccept & ~skipL;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    // Zero-count commands are popped without leaving IDLE.
    always_comb begin
        stateNext = state;
        pop       = 1'b0;
        start     = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (headNum != '0) begin
                        start     = 1'b1;
                        stateNext = RUN;
                    end
                end
            end
            RUN: begin
                if (lastAccept) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            skipL   <= 1'b0;
            sampleL <= 1'b0;
            cfgL    <= 3'd0;
        end else if (start) begin
            cnt     <= headNum;
            skipL   <= head[1];
            sampleL <= head[0];
            cfgL    <= config_whichSampling;
        end else if (accept) begin
            cnt <= cnt - 1'b1;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : gLane
        assign sampled[g*16 +: 16] = sampleLane(k__out[g*16 +: 16], cfgL);
    end

    assign wordNext = sampleL ? sampled : k__out;

    // A refill in the same cycle as a drain keeps valid high.
    always_ff @(posedge clk) begin
        if (rst) begin
            hData  <= '0;
            hValid <= 1'b0;
            hLast  <= 1'b0;
        end else if (accept) begin
            hData  <= wordNext;
            hValid <= 1'b1;
            hLast  <= k__out_isLast;
        end else if (drain) begin
            hValid <= 1'b0;
            hLast  <= 1'b0;
        end
    end

    assign h__in         = hData;
    assign h__in_isReady = hValid;
    assign h__in_isLast  = hLast;
    assign busy          = (state == RUN) | hValid;

`ifdef ADAPTED_KECCAK_OUT_PIPE_STATS_EN
    logic hSample;
    logic [31:0] statsCnt;

    always_ff @(posedge clk) begin
        if (rst)         hSample <= 1'b0;
        else if (accept) hSample <= sampleL;
        else if (drain)  hSample <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst || stats_clear)
            statsCnt <= '0;
        else if (drain && hSample && statsCnt != 32'hFFFF_FFFF)
            statsCnt <= statsCnt + 32'd1;
    end

    assign stats_words = statsCnt;
`endif

endmodule
